// File: rtl/ecc_host_if.sv
// rtl/ecc_host_if.sv - host load/run/unload controller for one GF(2^163) ECC core
// Optional: ECC_IO_CHECKSUM_EN appends an XOR checksum word to the unload stream.

module ecc_host_if #(
    parameter int RUN_CYCLES = 3000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [162:0] Rx,
    output logic [162:0] Ry,
    input  logic [162:0] res_xx,
    input  logic [162:0] res_zz,
    output logic         core_rst,
    output logic         core_enable,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RUN     = 2'd1,
        S_CAPTURE = 2'd2,
        S_UNLOAD  = 2'd3
    } state_t;

    localparam logic [15:0] RUN_LAST = 16'(RUN_CYCLES - 1);
`ifdef ECC_IO_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd12;
`else
    localparam logic [3:0] LAST_IDX = 4'd11;
`endif

    // Word k of a 163-bit operand; word 5 naturally yields only bits [162:160].
    function automatic logic [31:0] f_word(input logic [162:0] v, input logic [2:0] k);
        return 32'(v >> {k, 5'd0});
    endfunction

    function automatic logic [162:0] f_insert(input logic [162:0] v, input logic [2:0] k,
                                              input logic [31:0] d);
        logic [162:0] m;
        m = 163'(32'hFFFF_FFFF) << {k, 5'd0};
        return (v & ~m) | (163'(d) << {k, 5'd0});
    endfunction

    state_t         r_state;
    state_t         w_next_state;
    logic [3:0]     r_idx;
    logic [15:0]    r_cnt;
    logic [162:0]   r_rx;
    logic [162:0]   r_ry;
    logic [162:0]   r_sh_xx;
    logic [162:0]   r_sh_zz;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [31:0]    r_out_data;
    logic           r_core_rst;
    logic           r_core_en;
    logic           r_busy;
    logic           r_done;
`ifdef ECC_IO_CHECKSUM_EN
    logic [31:0]    r_csum;
`endif

    logic           w_in_fire;
    logic           w_out_fire;
    logic [2:0]     w_slot;
    logic [3:0]     w_idx_inc;
    logic [31:0]    w_unload_word;

    always_comb begin
        w_in_fire     = in_valid & r_in_ready & (r_state == S_LOAD);
        w_out_fire    = out_ready & r_out_valid & (r_state == S_UNLOAD);
        w_slot        = (r_idx < 4'd6) ? r_idx[2:0] : 3'(r_idx - 4'd6);
        w_idx_inc     = r_idx + 4'd1;
        w_unload_word = (w_idx_inc < 4'd6) ? f_word(r_sh_xx, w_idx_inc[2:0])
                                           : f_word(r_sh_zz, 3'(w_idx_inc - 4'd6));
`ifdef ECC_IO_CHECKSUM_EN
        if (r_idx == 4'd11) begin
            w_unload_word = r_csum ^ r_out_data;
        end
`endif
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:    if (w_in_fire && r_idx == 4'd11) w_next_state = S_RUN;
                S_RUN:     if (r_cnt == RUN_LAST) w_next_state = S_CAPTURE;
                S_CAPTURE: w_next_state = S_UNLOAD;
                S_UNLOAD:  if (w_out_fire && r_idx == LAST_IDX) w_next_state = S_LOAD;
                default:   w_next_state = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_LOAD;
            r_idx       <= 4'd0;
            r_cnt       <= 16'd0;
            r_rx        <= '0;
            r_ry        <= '0;
            r_sh_xx     <= '0;
            r_sh_zz     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_core_rst  <= 1'b0;
            r_core_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef ECC_IO_CHECKSUM_EN
            r_csum      <= 32'd0;
`endif
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            if (abort) begin
                // Operands survive an abort; only sequencing state is cleared.
                r_idx       <= 4'd0;
                r_cnt       <= 16'd0;
                r_core_en   <= 1'b0;
                r_core_rst  <= 1'b0;
                r_out_valid <= 1'b0;
                r_in_ready  <= 1'b1;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_in_fire) begin
                            if (r_idx < 4'd6) r_rx <= f_insert(r_rx, w_slot, in_data);
                            else              r_ry <= f_insert(r_ry, w_slot, in_data);
                            if (r_idx == 4'd11) begin
                                r_idx      <= 4'd0;
                                r_cnt      <= 16'd0;
                                r_in_ready <= 1'b0;
                                r_core_rst <= 1'b1;
                                r_core_en  <= 1'b1;
                                r_busy     <= 1'b1;
                            end else begin
                                r_idx <= w_idx_inc;
                            end
                        end
                    end
                    S_RUN: begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == RUN_LAST) r_core_en <= 1'b0;
                    end
                    S_CAPTURE: begin
                        r_sh_xx     <= res_xx;
                        r_sh_zz     <= res_zz;
                        r_out_data  <= f_word(res_xx, 3'd0);
                        r_out_valid <= 1'b1;
                        r_idx       <= 4'd0;
`ifdef ECC_IO_CHECKSUM_EN
                        r_csum      <= 32'd0;
`endif
                    end
                    S_UNLOAD: begin
                        if (w_out_fire) begin
`ifdef ECC_IO_CHECKSUM_EN
                            r_csum <= r_csum ^ r_out_data;
`endif
                            if (r_idx == LAST_IDX) begin
                                r_idx       <= 4'd0;
                                r_out_valid <= 1'b0;
                                r_core_rst  <= 1'b0;
                                r_busy      <= 1'b0;
                                r_in_ready  <= 1'b1;
                                r_done      <= 1'b1;
                            end else begin
                                r_idx      <= w_idx_inc;
                                r_out_data <= w_unload_word;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign Rx          = r_rx;
    assign Ry          = r_ry;
    assign core_rst    = r_core_rst;
    assign core_enable = r_core_en;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_ecc_host_if.sv
// tb/tb_ecc_host_if.sv - scoreboard bench for ecc_host_if with a word-level reference model

module tb_ecc_host_if;

    localparam int RC = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic [162:0] Rx;
    logic [162:0] Ry;
    logic [162:0] res_xx = '0;
    logic [162:0] res_zz = '0;
    logic         core_rst;
    logic         core_enable;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mw[12];
    logic [31:0] ld_w[12];
    bit          bp_mode = 1'b0;
    bit          bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          bp_i = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_data = 32'd0;

    ecc_host_if #(.RUN_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .Rx(Rx), .Ry(Ry), .res_xx(res_xx), .res_zz(res_zz),
        .core_rst(core_rst), .core_enable(core_enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [162:0] got, input logic [162:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Operand value = sum of word_k * 2^(32k), truncated to 163 bits.
    function automatic logic [162:0] model_op(input int base);
        logic [162:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) v = v | (163'(mw[base + k]) << (32 * k));
        return v;
    endfunction

    function automatic logic [31:0] model_word(input logic [162:0] v, input int k);
        return 32'(v >> (32 * k));
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[162:0];
    endfunction

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_i % 4];
            bp_i++;
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_data", out_data, prev_data);
                check("hold_valid", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", out_data, e);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) done_cnt++;
        end
    end

    task automatic send_word(input logic [31:0] d);
        int gap;
        gap = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        check("in_ready_load", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 12; i++) begin
            send_word(ld_w[i]);
            mw[i] = ld_w[i];
        end
    endtask

    task automatic run_txn(input logic [162:0] cxx, input logic [162:0] czz);
        int          en_cnt;
        int          base_done;
        int          t;
        logic [31:0] x;
        load_all();
        check("rx_loaded", Rx, model_op(0));
        check("ry_loaded", Ry, model_op(6));
        check("in_ready_drop", in_ready, 1'b0);
        en_cnt = 0;
        for (int c = 1; c <= RC + 1; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom();
            if (c == RC + 1) begin
                res_xx = cxx;
                res_zz = czz;
            end else begin
                res_xx = rand163();
                res_zz = rand163();
            end
            @(negedge clk);
            if (core_enable) en_cnt++;
            if (c == 2) begin
                check("busy_run", busy, 1'b1);
                check("core_rst_run", core_rst, 1'b1);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("enable_cycles", en_cnt, RC);
        x = 32'd0;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(model_word(cxx, k));
            x = x ^ model_word(cxx, k);
        end
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(model_word(czz, k));
            x = x ^ model_word(czz, k);
        end
`ifdef ECC_IO_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        base_done = done_cnt;
        res_xx = rand163();
        res_zz = rand163();
        @(negedge clk);
        check("first_out_valid", out_valid, 1'b1);
        t = 0;
        while (!done && t < 400) begin
            @(posedge clk); #1;
            res_xx = rand163();
            res_zz = rand163();
            @(negedge clk);
            t++;
        end
        check("done_seen", done, 1'b1);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        check("core_rst_after", core_rst, 1'b0);
        check("busy_after", busy, 1'b0);
        check("in_ready_after", in_ready, 1'b1);
        check("rx_held", Rx, model_op(0));
        check("ry_held", Ry, model_op(6));
        @(posedge clk); #1;
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("done_once", done_cnt - base_done, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [167:0] pat;
        for (int i = 0; i < 12; i++) mw[i] = 32'd0;

        #1 rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_rx", Rx, '0);
        check("rst_ry", Ry, '0);
        check("rst_core_rst", core_rst, 1'b0);
        check("rst_core_en", core_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        bp_mode = 1'b1;
        for (int i = 0; i < 12; i++) ld_w[i] = 32'd0;
        ld_w[0]  = 32'h0000_0001;
        ld_w[11] = 32'hFFFF_FFFF;
        pat = {21{8'h5A}};
        run_txn(pat[162:0], 163'h3);
        check("directed_rx", Rx, 163'h1);
        check("directed_ry", Ry, {3'b111, 160'd0});
        bp_mode = 1'b0;

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 12; i++) ld_w[i] = $urandom();
            run_txn(rand163(), rand163());
        end

        for (int i = 0; i < 4; i++) begin
            ld_w[i] = $urandom();
            send_word(ld_w[i]);
            mw[i] = ld_w[i];
        end
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        abort    = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_rx", Rx, model_op(0));
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_core_en", core_enable, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) ld_w[i] = $urandom();
        run_txn(rand163(), rand163());

        for (int i = 0; i < 12; i++) ld_w[i] = $urandom();
        load_all();
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) mw[i] = 32'd0;
        check("midrun_in_ready", in_ready, 1'b1);
        check("midrun_out_valid", out_valid, 1'b0);
        check("midrun_out_data", out_data, 32'd0);
        check("midrun_rx", Rx, '0);
        check("midrun_ry", Ry, '0);
        check("midrun_core_rst", core_rst, 1'b0);
        check("midrun_core_en", core_enable, 1'b0);
        check("midrun_busy", busy, 1'b0);
        check("midrun_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) ld_w[i] = $urandom();
        run_txn(rand163(), rand163());

        for (int i = 0; i < 12; i++) ld_w[i] = $urandom();
        run_txn({163{1'b1}}, {163{1'b1}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
